wb_writer: RTL and testbench

Writeback-stage unit of the 5-stage MIPS32 pipeline: the sole write-port driver of the general register file. It holds the MEM/WB pipeline register, extracts and extends load data, selects the writeback result, and arbitrates the single register-file write port between pipeline instructions and the multiply/divide unit (MDU). It also keeps a retired-instruction counter for debug.

---
 rtl/wb_writer.sv | 130 +++++++++++++
 tb/tb_wb_writer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_writer.sv
// wb_writer: MIPS32 writeback stage. It holds the MEM/WB register, extracts
// load data, selects the result and arbitrates the single GPR write port
// between the pipeline and the multiply/divide unit. It also counts retired
// instructions for debug.
module wb_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [4:0]  mem_a3,
    input  logic [1:0]  mem_src,
    input  logic [31:0] mem_alu,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] mem_pc,
    input  logic [2:0]  mem_ltype,
    input  logic        flush,
    input  logic        md_req,
    input  logic [4:0]  md_a3,
    input  logic [31:0] md_wd,
    output logic        md_ack,
    output logic        wb_hold,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd3,
    output logic        rf_we3,
    output logic [31:0] retired
);

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
    } wb_entry_t;

    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC8  = 2'b10;

    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    wb_entry_t   wb;
    logic [1:0]  starve;
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;
    logic [31:0] ld_data;
    logic [31:0] result;
    logic        pipe_own;

    // Load extraction: pick the addressed half/byte (little-endian) and extend
    always_comb begin
        ld_half = mem_alu[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (mem_alu[1:0])
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        case (mem_ltype)
            LT_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            LT_LHU:  ld_data = {16'h0000, ld_half};
            LT_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            LT_LBU:  ld_data = {24'h000000, ld_byte};
            default: ld_data = mem_rdata;
        endcase
    end

    // Writeback result select; PC+8 wraps naturally at 32 bits
    always_comb begin
        case (mem_src)
            SRC_LOAD: result = ld_data;
            SRC_PC8:  result = mem_pc + 32'd8;
            default:  result = mem_alu;
        endcase
    end

    // MEM/WB register: a held or flushed cycle latches a bubble
    always_ff @(posedge clk) begin
        if (reset)
            wb <= '0;
        else if (flush || wb_hold)
            wb <= '0;
        else
            wb <= '{valid: mem_valid, we: mem_we, a3: mem_a3, wd: result};
    end

    // Starvation counter: consecutive un-acked MDU request cycles, saturating
    always_ff @(posedge clk) begin
        if (reset)
            starve <= 2'd0;
        else if (md_req && !md_ack)
            starve <= (starve == 2'd3) ? 2'd3 : starve + 2'd1;
        else
            starve <= 2'd0;
    end

    // Stall upstream once the MDU has waited long enough; registered state only
    assign wb_hold = (starve == 2'd3);

    // Retired-instruction counter: every valid WB entry, writing or not
    always_ff @(posedge clk) begin
        if (reset)
            retired <= 32'd0;
        else if (wb.valid)
            retired <= retired + 32'd1;
    end

    assign pipe_own = wb.valid && wb.we && (wb.a3 != 5'd0);

    // Write-port arbitration: pipeline first, MDU second; writes to $0 are
    // acked to the MDU but never enabled
    always_comb begin
        rf_we3 = 1'b0;
        rf_a3  = 5'd0;
        rf_wd3 = 32'd0;
        md_ack = 1'b0;
        if (pipe_own) begin
            rf_we3 = 1'b1;
            rf_a3  = wb.a3;
            rf_wd3 = wb.wd;
        end else if (md_req) begin
            md_ack = 1'b1;
            rf_we3 = (md_a3 != 5'd0);
            rf_a3  = md_a3;
            rf_wd3 = md_wd;
        end
    end

endmodule

// File: tb/tb_wb_writer.sv
// Bench for wb_writer: directed cases plus randomized traffic, checked by a
// queue-based scoreboard fed from a behavioural model of the writeback stage.
module tb_wb_writer;

    logic        clk = 1'b0;
    logic        reset, mem_valid, mem_we, flush, md_req;
    logic [4:0]  mem_a3, md_a3;
    logic [1:0]  mem_src;
    logic [31:0] mem_alu, mem_rdata, mem_pc, md_wd;
    logic [2:0]  mem_ltype;
    logic        md_ack, wb_hold, rf_we3;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3, retired;

    always #5 clk = ~clk;

    wb_writer dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_we(mem_we),
        .mem_a3(mem_a3), .mem_src(mem_src), .mem_alu(mem_alu),
        .mem_rdata(mem_rdata), .mem_pc(mem_pc), .mem_ltype(mem_ltype),
        .flush(flush), .md_req(md_req), .md_a3(md_a3), .md_wd(md_wd),
        .md_ack(md_ack), .wb_hold(wb_hold), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
        .rf_we3(rf_we3), .retired(retired)
    );

    typedef struct {
        logic        we;
        logic        ack;
        logic        hold;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] ret;
        logic        cmp_port;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 0;

    // Reference model state: the instruction sitting in WB, MDU wait length,
    // retired count
    logic        mv = 0, mwe = 0;
    logic [4:0]  ma3 = 0;
    logic [31:0] mwd = 0, mret = 0;
    int          mwait = 0;

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] o,
                                             input logic [2:0] t);
        logic [31:0] h, b;
        h = w >> {o[1], 4'b0000};
        b = w >> {o, 3'b000};
        case (t)
            3'd1:    return 32'($signed(h[15:0]));
            3'd2:    return {16'h0, h[15:0]};
            3'd3:    return 32'($signed(b[7:0]));
            3'd4:    return {24'h0, b[7:0]};
            default: return w;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive MEM inputs, queue the expected port state for
    // this cycle, then advance the model across the edge.
    task automatic cyc(input logic v, input logic we, input logic [4:0] a3,
                       input logic [1:0] src, input logic [31:0] alu,
                       input logic [31:0] rd, input logic [31:0] pc,
                       input logic [2:0] lt, input logic fl, input logic rs);
        exp_t        e;
        logic        own, ack, hold;
        logic [31:0] res;
        mem_valid = v; mem_we = we; mem_a3 = a3; mem_src = src; mem_alu = alu;
        mem_rdata = rd; mem_pc = pc; mem_ltype = lt; flush = fl; reset = rs;
        own  = mv && mwe && (ma3 != 0);
        ack  = !own && md_req;
        hold = (mwait == 3);
        e.we = own || (ack && md_a3 != 0);
        e.ack = ack;
        e.hold = hold;
        e.a3 = own ? ma3 : (ack ? md_a3 : 5'd0);
        e.wd = own ? mwd : (ack ? md_wd : 32'd0);
        e.ret = mret;
        e.cmp_port = !(ack && md_a3 == 0);
        if (chk_en) q.push_back(e);
        res = (src == 2'b01) ? ref_load(rd, alu[1:0], lt) :
              (src == 2'b10) ? pc + 32'd8 : alu;
        @(posedge clk);
        #1;
        if (rs) begin
            mv = 0; mwe = 0; ma3 = 0; mwd = 0; mret = 0; mwait = 0;
        end else begin
            mret  = mret + {31'd0, mv};
            mwait = (md_req && !ack) ? ((mwait < 3) ? mwait + 1 : 3) : 0;
            if (fl || hold) begin
                mv = 0; mwe = 0; ma3 = 0; mwd = 0;
            end else begin
                mv = v; mwe = we; ma3 = a3; mwd = res;
            end
        end
        if (ack) md_req = 0;
    endtask

    task automatic idle();
        cyc(0, 0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 3'd0, 0, 0);
    endtask

    // Monitor: compare every cycle's port state against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        bit   bad;
        if (q.size() > 0) begin
            e = q.pop_front();
            bad = (rf_we3 !== e.we) || (md_ack !== e.ack) || (wb_hold !== e.hold) ||
                  (retired !== e.ret) ||
                  (e.cmp_port && ((rf_a3 !== e.a3) || (rf_wd3 !== e.wd)));
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL port: we=%b ack=%b hold=%b a3=%0d wd=%h ret=%0d want we=%b ack=%b hold=%b a3=%0d wd=%h ret=%0d",
                         rf_we3, md_ack, wb_hold, rf_a3, rf_wd3, retired,
                         e.we, e.ack, e.hold, e.a3, e.wd, e.ret);
            end
        end
    end

    initial begin
        logic [31:0] r0;
        md_req = 0; md_a3 = 0; md_wd = 0;
        cyc(0, 0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 3'd0, 0, 1);
        chk_en = 1;
        chk("rst_we", {31'd0, rf_we3}, 32'd0);
        chk("rst_ack", {31'd0, md_ack}, 32'd0);
        chk("rst_hold", {31'd0, wb_hold}, 32'd0);
        chk("rst_ret", retired, 32'd0);

        // LW then retire count
        cyc(1, 1, 5'd5, 2'b01, 32'h0, 32'h89ABCDEF, 32'h100, 3'd0, 0, 0);
        chk("lw_we", {31'd0, rf_we3}, 32'd1);
        chk("lw_a3", {27'd0, rf_a3}, 32'd5);
        chk("lw_wd", rf_wd3, 32'h89ABCDEF);
        idle();
        chk("lw_ret", retired, 32'd1);

        // Sub-word loads
        cyc(1, 1, 5'd6, 2'b01, 32'h3, 32'h80FF7F01, 32'h0, 3'd3, 0, 0);
        chk("lb", rf_wd3, 32'hFFFFFF80);
        cyc(1, 1, 5'd6, 2'b01, 32'h3, 32'h80FF7F01, 32'h0, 3'd4, 0, 0);
        chk("lbu", rf_wd3, 32'h00000080);
        cyc(1, 1, 5'd6, 2'b01, 32'h2, 32'h80FF7F01, 32'h0, 3'd1, 0, 0);
        chk("lh", rf_wd3, 32'hFFFF80FF);
        cyc(1, 1, 5'd6, 2'b01, 32'h1, 32'h80FF7F01, 32'h0, 3'd2, 0, 0);
        chk("lhu", rf_wd3, 32'h00007F01);

        // JAL link value, including wrap
        cyc(1, 1, 5'd31, 2'b10, 32'h0, 32'h0, 32'h00003000, 3'd0, 0, 0);
        chk("jal", rf_wd3, 32'h00003008);
        cyc(1, 1, 5'd31, 2'b10, 32'h0, 32'h0, 32'hFFFFFFFC, 3'd0, 0, 0);
        chk("jal_wrap", rf_wd3, 32'h00000004);

        // MDU grant during bubble, $0 write, non-writing entry
        idle();
        md_req = 1; md_a3 = 5'd8; md_wd = 32'h1234;
        #1;
        chk("md_bub_ack", {31'd0, md_ack}, 32'd1);
        chk("md_bub_wd", rf_wd3, 32'h1234);
        cyc(1, 1, 5'd0, 2'b00, 32'hDEAD, 32'h0, 32'h0, 3'd0, 0, 0);
        md_req = 1; md_a3 = 5'd9; md_wd = 32'h99;
        #1;
        chk("md_r0_ack", {31'd0, md_ack}, 32'd1);
        chk("md_r0_a3", {27'd0, rf_a3}, 32'd9);
        cyc(1, 0, 5'd7, 2'b00, 32'hBEEF, 32'h0, 32'h0, 3'd0, 0, 0);
        md_req = 1; md_a3 = 5'd11; md_wd = 32'h77;
        #1;
        chk("md_nowe_ack", {31'd0, md_ack}, 32'd1);
        idle();

        // Starvation: pipeline writes back-to-back while the MDU waits
        cyc(1, 1, 5'd1, 2'b00, 32'h11, 32'h0, 32'h0, 3'd0, 0, 0);
        md_req = 1; md_a3 = 5'd10; md_wd = 32'hABCD;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("starve_hold", {31'd0, wb_hold}, {31'd0, k == 4});
            cyc(1, 1, 5'(k + 1), 2'b00, 32'h20 + k, 32'h0, 32'h0, 3'd0, 0, 0);
        end
        #1;
        chk("starve_ack", {31'd0, md_ack}, 32'd1);
        chk("starve_wd", rf_wd3, 32'hABCD);
        r0 = retired;
        idle();
        chk("starve_ret", retired, r0);

        // Flush, then reset with a valid write in WB
        cyc(1, 1, 5'd3, 2'b00, 32'h55, 32'h0, 32'h0, 3'd0, 1, 0);
        chk("flush_we", {31'd0, rf_we3}, 32'd0);
        cyc(1, 1, 5'd4, 2'b00, 32'h66, 32'h0, 32'h0, 3'd0, 0, 0);
        cyc(0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 3'd0, 0, 1);
        chk("rst_mid_we", {31'd0, rf_we3}, 32'd0);
        chk("rst_mid_ret", retired, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if (!md_req && ($urandom % 4 == 0)) begin
                md_req = 1; md_a3 = 5'($urandom); md_wd = $urandom;
            end
            cyc(($urandom % 4) != 0, ($urandom % 4) != 0, 5'($urandom), 2'($urandom),
                $urandom, $urandom, $urandom, 3'($urandom),
                ($urandom % 8) == 0, ($urandom % 64) == 0);
        end
        idle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
